// File: rtl/snoop_pkg.sv
// Shared types and constants for the snooper-to-core dispatcher.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, picker policy constants, clog2 helper used to
// check the selection tag width at elaboration.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_DONE_WAIT = 2'd2
  } state_t;

  localparam int POLICY_FIXED = 0;
  localparam int POLICY_RR    = 1;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Core picker: chooses one requesting core by fixed priority or round-robin.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects whether any request is set.
//
// Ports:
//   req   in  N       request vector (core ready and enabled)
//   ptr   in  TAG_SZ  round-robin start index (ignored for fixed priority)
//   valid out 1       at least one request is set
//   tag   out TAG_SZ  index of the chosen core
module rr_pick import snoop_pkg::*; #(
  parameter int N      = 4,
  parameter int TAG_SZ = 5,
  parameter int POLICY = POLICY_RR
) (
  input  logic [N-1:0]      req,
  input  logic [TAG_SZ-1:0] ptr,
  output logic              valid,
  output logic [TAG_SZ-1:0] tag
);

  // ptr only matters for round-robin with more than one core.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  assign valid = |req;

  if (N == 1) begin : g_single
    assign tag = '0;
  end else if (POLICY == POLICY_FIXED) begin : g_fixed
    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
      tag = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) tag = TAG_SZ'(i);
      end
    end
  end else begin : g_rr
    // Rotate the request vector so bit 0 is the core at ptr, then take the
    // lowest set bit and map its offset back to a core index.
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;

    assign dbl = {req, req};
    assign rot = N'(dbl >> ptr);

    function automatic logic [TAG_SZ-1:0] wrap_add(input logic [TAG_SZ-1:0] base,
                                                   input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return TAG_SZ'(s);
    endfunction

    always_comb begin
      tag = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (rot[i]) tag = wrap_add(ptr, i);
      end
    end
  end

endmodule

// File: rtl/snoop_dispatch.sv
// Dispatches each snooped packet to one ready, enabled packetfilter core.
// Latency: grant pulse 1 cycle after the rdy/ack handshake; write/done
//   forwarding is combinational in STREAM; PIPE=1 adds one cycle to every
//   core-side output.
// Backpressure: rdy drops while a packet is in flight; done is held by the
//   snooper until done_ack, which mirrors the selected core's sn_done_ack.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   addr/wr_data/wr_en/byte_inc  snooper write stream
//   done, done_ack            end-of-packet handshake with the snooper
//   ack, rdy                  packet-start handshake with the snooper
//   core_en, rdy_for_sn       per-core enable mask and readiness
//   sn_done_ack               per-core acknowledge of sn_done
//   sn_addr/sn_wr_data/sn_byte_inc  broadcast write stream to all cores
//   sn_wr_en, sn_done, rdy_for_sn_ack  one-hot per-core strobes
//   sel_tag, busy             selected core index, packet in flight
module snoop_dispatch import snoop_pkg::*; #(
  parameter int SN_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int INC_WIDTH     = 8,
  parameter int N             = 4,
  parameter int TAG_SZ        = 5,
  parameter int POLICY        = POLICY_RR,
  parameter int PIPE          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SN_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  input  logic [INC_WIDTH-1:0]     byte_inc,
  input  logic                     done,
  input  logic                     ack,
  output logic                     rdy,
  output logic                     done_ack,
  input  logic [N-1:0]             core_en,
  input  logic [N-1:0]             rdy_for_sn,
  input  logic [N-1:0]             sn_done_ack,
  output logic [SN_ADDR_WIDTH-1:0] sn_addr,
  output logic [DATA_WIDTH-1:0]    sn_wr_data,
  output logic [INC_WIDTH-1:0]     sn_byte_inc,
  output logic [N-1:0]             sn_wr_en,
  output logic [N-1:0]             sn_done,
  output logic [N-1:0]             rdy_for_sn_ack,
  output logic [TAG_SZ-1:0]        sel_tag,
  output logic                     busy
);

  if (N < 1 || N > 32 || TAG_SZ < clog2(N)) begin : g_param_check
    $error("snoop_dispatch: N must be 1..32 and TAG_SZ >= clog2(N)");
  end

  state_t            state, state_nxt;
  logic [TAG_SZ-1:0] ptr;
  logic [TAG_SZ-1:0] pick_tag;
  logic              pick_valid;
  logic [N-1:0]      req;
  logic [N-1:0]      pick_oh;
  logic [N-1:0]      sel_oh;
  logic [N-1:0]      grant_pulse;
  logic              grant;
  logic              ack_hit;

  // Core-side values before the optional output register.
  logic [N-1:0]      wr_en_c;
  logic [N-1:0]      done_c;

  assign req = rdy_for_sn & core_en;

  rr_pick #(
    .N      (N),
    .TAG_SZ (TAG_SZ),
    .POLICY (POLICY)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .tag   (pick_tag)
  );

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < N; i++) begin
      pick_oh[i] = (pick_tag == TAG_SZ'(i));
    end
  end

  assign grant   = (state == ST_IDLE) && pick_valid && ack && !rst;
  // Only the selected core's acknowledge counts; other bits are masked off.
  assign ack_hit = |(sn_done_ack & sel_oh);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (grant)   state_nxt = ST_STREAM;
      ST_STREAM:    if (done)    state_nxt = ST_DONE_WAIT;
      ST_DONE_WAIT: if (ack_hit) state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy      = 1'b0;
    done_ack = 1'b0;
    busy     = (state != ST_IDLE);
    wr_en_c  = '0;
    done_c   = '0;
    case (state)
      ST_IDLE: begin
        rdy = pick_valid && !rst;
      end
      ST_STREAM: begin
        // The write in the done cycle is still forwarded.
        if (wr_en) wr_en_c = sel_oh;
        if (done)  done_c  = sel_oh;
      end
      ST_DONE_WAIT: begin
        done_c   = sel_oh;
        done_ack = ack_hit && !rst;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------ selection registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_tag     <= '0;
      sel_oh      <= '0;
      ptr         <= '0;
      grant_pulse <= '0;
    end else begin
      grant_pulse <= grant ? pick_oh : '0;
      if (grant) begin
        sel_tag <= pick_tag;
        sel_oh  <= pick_oh;
        if (POLICY == POLICY_RR && N > 1) begin
          ptr <= (pick_tag == TAG_SZ'(N - 1)) ? '0 : pick_tag + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------ core-side outputs
  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        sn_addr        <= '0;
        sn_wr_data     <= '0;
        sn_byte_inc    <= '0;
        sn_wr_en       <= '0;
        sn_done        <= '0;
        rdy_for_sn_ack <= '0;
      end else begin
        sn_addr        <= addr;
        sn_wr_data     <= wr_data;
        sn_byte_inc    <= byte_inc;
        sn_wr_en       <= wr_en_c;
        sn_done        <= done_c;
        rdy_for_sn_ack <= grant_pulse;
      end
    end
  end else begin : g_direct
    assign sn_addr        = addr;
    assign sn_wr_data     = wr_data;
    assign sn_byte_inc    = byte_inc;
    assign sn_wr_en       = wr_en_c;
    assign sn_done        = done_c;
    assign rdy_for_sn_ack = grant_pulse;
  end

endmodule
